// File: rtl/id_ex_stage_pkg.sv
// Shared encodings and helpers for the ID/EX pipeline register.
package id_ex_stage_pkg;

   typedef enum logic [3:0] {
      ALU_AND       = 4'b0000,
      ALU_OR        = 4'b0001,
      ALU_ADD       = 4'b0010,
      ALU_SUB       = 4'b0011,
      ALU_SLT       = 4'b0100,
      ALU_NOR       = 4'b0101,
      ALU_EQ        = 4'b0110,
      ALU_SLL       = 4'b1000,
      ALU_SRL       = 4'b1001,
      ALU_XOR       = 4'b1010,
      ALU_BLTZ      = 4'b1011,
      ALU_BGEZ_BLEZ = 4'b1100,
      ALU_BGTZ      = 4'b1101,
      ALU_MUL       = 4'b1110,
      ALU_NOP       = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      MEM_WORD = 2'b00,
      MEM_HALF = 2'b01,
      MEM_BYTE = 2'b10
   } mem_size_e;

   // Control bundle exactly as produced by the decoder.
   typedef struct packed {
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src;
      logic       branch;
      logic       mem_write;
      logic       mem_read;
      logic       mem_to_reg;
      logic       jump;
      logic [3:0] alu_op;
      logic [1:0] mem_size;
   } ctrl_t;

   // A bubble has no side effects: nothing written, no memory access.
   localparam ctrl_t BUBBLE_CTRL = '{
      reg_write:  1'b0,
      reg_dst:    1'b0,
      alu_src:    1'b0,
      branch:     1'b0,
      mem_write:  1'b0,
      mem_read:   1'b0,
      mem_to_reg: 1'b0,
      jump:       1'b0,
      alu_op:     ALU_NOP,
      mem_size:   MEM_WORD
   };

   // rt is a real source when the ALU takes it as operand B or a store writes it.
   function automatic logic uses_rt(input logic alu_src, input logic mem_write);
      return (!alu_src) || mem_write;
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decoder-to-EX bus: decoded fields in, registered fields, stall and debug counters out.
interface id_ex_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic              id_valid;
   logic              id_RegWrite, id_RegDst, id_ALUSrc, id_Branch;
   logic              id_MemWrite, id_MemRead, id_MemToReg, id_Jump;
   logic [3:0]        id_ALUOp;
   logic [1:0]        id_MemSize;
   logic [DATA_W-1:0] id_PCPlus4, id_ReadData1, id_ReadData2, id_Imm;
   logic [REG_AW-1:0] id_Rs, id_Rt, id_Rd;
   logic              flush;

   logic              ex_valid;
   logic              ex_RegWrite, ex_RegDst, ex_ALUSrc, ex_Branch;
   logic              ex_MemWrite, ex_MemRead, ex_MemToReg, ex_Jump;
   logic [3:0]        ex_ALUOp;
   logic [1:0]        ex_MemSize;
   logic [DATA_W-1:0] ex_PCPlus4, ex_ReadData1, ex_ReadData2, ex_Imm;
   logic [REG_AW-1:0] ex_Rs, ex_Rt, ex_Rd;
   logic              stall;
   logic [CNT_W-1:0]  stall_count, flush_count;

   modport master (
      output id_valid, id_RegWrite, id_RegDst, id_ALUSrc, id_Branch,
             id_MemWrite, id_MemRead, id_MemToReg, id_Jump, id_ALUOp, id_MemSize,
             id_PCPlus4, id_ReadData1, id_ReadData2, id_Imm, id_Rs, id_Rt, id_Rd, flush,
      input  ex_valid, ex_RegWrite, ex_RegDst, ex_ALUSrc, ex_Branch,
             ex_MemWrite, ex_MemRead, ex_MemToReg, ex_Jump, ex_ALUOp, ex_MemSize,
             ex_PCPlus4, ex_ReadData1, ex_ReadData2, ex_Imm, ex_Rs, ex_Rt, ex_Rd,
             stall, stall_count, flush_count
   );

   modport slave (
      input  id_valid, id_RegWrite, id_RegDst, id_ALUSrc, id_Branch,
             id_MemWrite, id_MemRead, id_MemToReg, id_Jump, id_ALUOp, id_MemSize,
             id_PCPlus4, id_ReadData1, id_ReadData2, id_Imm, id_Rs, id_Rt, id_Rd, flush,
      output ex_valid, ex_RegWrite, ex_RegDst, ex_ALUSrc, ex_Branch,
             ex_MemWrite, ex_MemRead, ex_MemToReg, ex_Jump, ex_ALUOp, ex_MemSize,
             ex_PCPlus4, ex_ReadData1, ex_ReadData2, ex_Imm, ex_Rs, ex_Rt, ex_Rd,
             stall, stall_count, flush_count
   );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the instruction in ID.
module id_ex_stage_hazard_detect
   import id_ex_stage_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              active,
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              id_valid,
   input  logic              id_alu_src,
   input  logic              id_mem_write,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              flush,
   output logic              hazard,
   output logic              stall
);

   logic rs_match;
   logic rt_match;

   // $0 never carries a dependency, so a load into it cannot cause a stall.
   always_comb begin
      rs_match = (ex_rt == id_rs);
      rt_match = uses_rt(id_alu_src, id_mem_write) && (ex_rt == id_rt);
      hazard   = ex_valid && ex_mem_read && (ex_rt != '0) && id_valid && (rs_match || rt_match);
      stall    = active && hazard && !flush;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush handling and debug counters.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic     Clk,
   input  logic     Reset,
   id_ex_stage_if.slave bus
);

   ctrl_t             id_ctrl;
   ctrl_t             ex_ctrl;
   logic              ex_valid;
   logic [DATA_W-1:0] ex_pc_plus4, ex_rd1, ex_rd2, ex_imm;
   logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
   logic [CNT_W-1:0]  stall_count, flush_count;
   logic              hazard;
   logic              stall;
   logic              load_bubble;

   // Pack the decoder outputs into one bundle so capture and bubble are a single assignment.
   always_comb begin
      id_ctrl.reg_write  = bus.id_RegWrite;
      id_ctrl.reg_dst    = bus.id_RegDst;
      id_ctrl.alu_src    = bus.id_ALUSrc;
      id_ctrl.branch     = bus.id_Branch;
      id_ctrl.mem_write  = bus.id_MemWrite;
      id_ctrl.mem_read   = bus.id_MemRead;
      id_ctrl.mem_to_reg = bus.id_MemToReg;
      id_ctrl.jump       = bus.id_Jump;
      id_ctrl.alu_op     = bus.id_ALUOp;
      id_ctrl.mem_size   = bus.id_MemSize;
   end

   id_ex_stage_hazard_detect #(
      .REG_AW (REG_AW)
   ) u_hazard (
      .active       (Reset),
      .ex_valid     (ex_valid),
      .ex_mem_read  (ex_ctrl.mem_read),
      .ex_rt        (ex_rt),
      .id_valid     (bus.id_valid),
      .id_alu_src   (bus.id_ALUSrc),
      .id_mem_write (bus.id_MemWrite),
      .id_rs        (bus.id_Rs),
      .id_rt        (bus.id_Rt),
      .flush        (bus.flush),
      .hazard       (hazard),
      .stall        (stall)
   );

   // Flush, hazard and an empty decode slot all send a bubble into EX.
   assign load_bubble = bus.flush || hazard || !bus.id_valid;

   // Pipeline register; bubbles zero the datapath so EX contents are deterministic.
   always_ff @(posedge Clk) begin
      if (!Reset || load_bubble) begin
         ex_valid    <= 1'b0;
         ex_ctrl     <= BUBBLE_CTRL;
         ex_pc_plus4 <= '0;
         ex_rd1      <= '0;
         ex_rd2      <= '0;
         ex_imm      <= '0;
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_rd       <= '0;
      end else begin
         ex_valid    <= 1'b1;
         ex_ctrl     <= id_ctrl;
         ex_pc_plus4 <= bus.id_PCPlus4;
         ex_rd1      <= bus.id_ReadData1;
         ex_rd2      <= bus.id_ReadData2;
         ex_imm      <= bus.id_Imm;
         ex_rs       <= bus.id_Rs;
         ex_rt       <= bus.id_Rt;
         ex_rd       <= bus.id_Rd;
      end
   end

   // Saturating debug counters; a flush takes precedence, so it never also counts as a stall.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else if (bus.flush) begin
         if (flush_count != '1) flush_count <= flush_count + 1'b1;
      end else if (hazard) begin
         if (stall_count != '1) stall_count <= stall_count + 1'b1;
      end
   end

   assign bus.ex_valid     = ex_valid;
   assign bus.ex_RegWrite  = ex_ctrl.reg_write;
   assign bus.ex_RegDst    = ex_ctrl.reg_dst;
   assign bus.ex_ALUSrc    = ex_ctrl.alu_src;
   assign bus.ex_Branch    = ex_ctrl.branch;
   assign bus.ex_MemWrite  = ex_ctrl.mem_write;
   assign bus.ex_MemRead   = ex_ctrl.mem_read;
   assign bus.ex_MemToReg  = ex_ctrl.mem_to_reg;
   assign bus.ex_Jump      = ex_ctrl.jump;
   assign bus.ex_ALUOp     = ex_ctrl.alu_op;
   assign bus.ex_MemSize   = ex_ctrl.mem_size;
   assign bus.ex_PCPlus4   = ex_pc_plus4;
   assign bus.ex_ReadData1 = ex_rd1;
   assign bus.ex_ReadData2 = ex_rd2;
   assign bus.ex_Imm       = ex_imm;
   assign bus.ex_Rs        = ex_rs;
   assign bus.ex_Rt        = ex_rt;
   assign bus.ex_Rd        = ex_rd;
   assign bus.stall        = stall;
   assign bus.stall_count  = stall_count;
   assign bus.flush_count  = flush_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed instruction sequences plus a random tail,
// checked every cycle against an instruction-level model.
module tb_id_ex_stage;

   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   typedef struct packed {
      logic        valid;
      logic        reg_write, reg_dst, alu_src, branch, mem_write, mem_read, mem_to_reg, jump;
      logic [3:0]  alu_op;
      logic [1:0]  mem_size;
      logic [31:0] pc, rd1, rd2, imm;
      logic [4:0]  rs, rt, rd;
   } rec_t;

   logic Clk;
   logic Reset;
   logic flush;
   rec_t drv;
   rec_t got;

   int   n_checks = 0;
   int   n_fail   = 0;
   bit   chk_en   = 1'b0;
   bit   m_init   = 1'b0;
   rec_t m_ex;
   int   m_sc, m_fc;

   id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(CNT_W)) bus ();

   id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(CNT_W)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   assign bus.id_valid     = drv.valid;
   assign bus.id_RegWrite  = drv.reg_write;
   assign bus.id_RegDst    = drv.reg_dst;
   assign bus.id_ALUSrc    = drv.alu_src;
   assign bus.id_Branch    = drv.branch;
   assign bus.id_MemWrite  = drv.mem_write;
   assign bus.id_MemRead   = drv.mem_read;
   assign bus.id_MemToReg  = drv.mem_to_reg;
   assign bus.id_Jump      = drv.jump;
   assign bus.id_ALUOp     = drv.alu_op;
   assign bus.id_MemSize   = drv.mem_size;
   assign bus.id_PCPlus4   = drv.pc;
   assign bus.id_ReadData1 = drv.rd1;
   assign bus.id_ReadData2 = drv.rd2;
   assign bus.id_Imm       = drv.imm;
   assign bus.id_Rs        = drv.rs;
   assign bus.id_Rt        = drv.rt;
   assign bus.id_Rd        = drv.rd;
   assign bus.flush        = flush;

   assign got = {bus.ex_valid, bus.ex_RegWrite, bus.ex_RegDst, bus.ex_ALUSrc, bus.ex_Branch,
                 bus.ex_MemWrite, bus.ex_MemRead, bus.ex_MemToReg, bus.ex_Jump, bus.ex_ALUOp,
                 bus.ex_MemSize, bus.ex_PCPlus4, bus.ex_ReadData1, bus.ex_ReadData2, bus.ex_Imm,
                 bus.ex_Rs, bus.ex_Rt, bus.ex_Rd};

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [159:0] g, input logic [159:0] e);
      n_checks++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, g, e, $time);
      end
   endtask

   function automatic rec_t bubble();
      rec_t r = '0;
      r.alu_op = 4'hF;
      return r;
   endfunction

   // The instruction in ID needs a register the load in EX has not produced yet.
   function automatic bit model_hazard();
      bit reads_rt;
      if (!(m_ex.valid && m_ex.mem_read) || m_ex.rt == 5'd0 || !drv.valid) return 1'b0;
      reads_rt = !drv.alu_src || drv.mem_write;
      return (m_ex.rt == drv.rs) || (reads_rt && m_ex.rt == drv.rt);
   endfunction

   function automatic bit model_stall();
      return Reset && !flush && model_hazard();
   endfunction

   // Instruction-level model of what EX holds after each edge.
   always @(posedge Clk) begin
      if (!Reset) begin
         m_ex = bubble(); m_sc = 0; m_fc = 0;
      end else if (flush) begin
         m_ex = bubble(); m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
      end else if (model_hazard()) begin
         m_ex = bubble(); m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
      end else if (!drv.valid) begin
         m_ex = bubble();
      end else begin
         m_ex = drv;
      end
      m_init = 1'b1;
   end

   // Registered outputs checked mid-low-phase; stall checked after the inputs settle.
   always begin
      @(negedge Clk);
      if (chk_en && m_init) begin
         chk("ex_state", got, m_ex);
         chk("stall_count", bus.stall_count, m_sc[CNT_W-1:0]);
         chk("flush_count", bus.flush_count, m_fc[CNT_W-1:0]);
      end
      #4;
      if (chk_en) chk("stall", bus.stall, model_stall());
   end

   function automatic rec_t mk(input logic rw, rdst, asrc, mw, mr, m2r, input logic [3:0] op,
                               input logic [4:0] rs, rt, rd, input logic [31:0] a, b, imm);
      rec_t r = '0;
      r.valid = 1'b1; r.reg_write = rw; r.reg_dst = rdst; r.alu_src = asrc;
      r.mem_write = mw; r.mem_read = mr; r.mem_to_reg = m2r; r.alu_op = op;
      r.rs = rs; r.rt = rt; r.rd = rd; r.rd1 = a; r.rd2 = b; r.imm = imm;
      r.pc = 32'h0000_0100 + {27'd0, rd};
      return r;
   endfunction

   function automatic rec_t add_i(input logic [4:0] rs, rt, rd, input logic [31:0] a, b);
      return mk(1, 1, 0, 0, 0, 1, 4'b0010, rs, rt, rd, a, b, 32'd0);
   endfunction

   function automatic rec_t lw_i(input logic [4:0] rs, rt);
      return mk(1, 0, 1, 0, 1, 0, 4'b0010, rs, rt, 5'd0, 32'h40, 32'd0, 32'd4);
   endfunction

   function automatic rec_t addi_i(input logic [4:0] rs, rt);
      return mk(1, 0, 1, 0, 0, 1, 4'b0010, rs, rt, 5'd0, 32'h11, 32'h22, 32'hFFFF_FFF0);
   endfunction

   function automatic rec_t rand_rec();
      rec_t r;
      r.valid      = ($urandom_range(0, 3) != 0);
      r.reg_write  = 1'($urandom); r.reg_dst  = 1'($urandom);
      r.alu_src    = 1'($urandom); r.branch   = 1'($urandom);
      r.mem_write  = 1'($urandom); r.mem_read = 1'($urandom);
      r.mem_to_reg = 1'($urandom); r.jump     = 1'($urandom);
      r.alu_op     = 4'($urandom); r.mem_size = 2'($urandom_range(0, 2));
      r.pc = $urandom; r.rd1 = $urandom; r.rd2 = $urandom; r.imm = $urandom;
      r.rs = 5'($urandom_range(0, 3)); r.rt = 5'($urandom_range(0, 3));
      r.rd = 5'($urandom);
      return r;
   endfunction

   task automatic tick();
      @(negedge Clk);
      #1;
   endtask

   initial begin
      Reset = 1'b0;
      flush = 1'b0;
      drv   = rand_rec();
      chk_en = 1'b1;
      tick();
      drv = rand_rec(); flush = 1'b1;
      tick();
      chk("lit_reset_valid", got.valid, 1'b0);
      chk("lit_reset_aluop", got.alu_op, 4'hF);
      chk("lit_reset_counts", {bus.stall_count, bus.flush_count}, 8'h00);
      chk("lit_reset_stall", bus.stall, 1'b0);

      // Plain pass-through.
      Reset = 1'b1; flush = 1'b0;
      drv = add_i(5'd8, 5'd9, 5'd10, 32'd5, 32'd7);
      #2 chk("lit_add_stall", bus.stall, 1'b0);
      tick();
      chk("lit_add_valid", got.valid, 1'b1);
      chk("lit_add_fields", {got.alu_op, got.rs, got.rt, got.rd}, {4'b0010, 5'd8, 5'd9, 5'd10});
      chk("lit_add_data", {got.rd1, got.rd2}, {32'd5, 32'd7});

      // Load-use: one bubble, then the consumer goes through.
      drv = lw_i(5'd29, 5'd9);
      tick();
      drv = add_i(5'd9, 5'd10, 5'd11, 32'd1, 32'd2);
      #2 chk("lit_lu_stall", bus.stall, 1'b1);
      tick();
      chk("lit_lu_bubble", {got.valid, got.alu_op}, {1'b0, 4'hF});
      chk("lit_lu_count", bus.stall_count, 4'd1);
      chk("lit_lu_stall_clear", bus.stall, 1'b0);
      tick();
      chk("lit_lu_capture", {got.valid, got.rs, got.rd}, {1'b1, 5'd9, 5'd11});

      // Immediate form does not read rt; a load into $0 is never a dependency.
      drv = lw_i(5'd29, 5'd9);
      tick();
      drv = addi_i(5'd4, 5'd9);
      #2 chk("lit_addi_nostall", bus.stall, 1'b0);
      tick();
      drv = lw_i(5'd29, 5'd0);
      tick();
      drv = add_i(5'd0, 5'd0, 5'd3, 32'd0, 32'd0);
      #2 chk("lit_r0_nostall", bus.stall, 1'b0);
      tick();

      // Back-to-back dependent loads each get their own bubble.
      drv = lw_i(5'd29, 5'd9);
      tick();
      drv = lw_i(5'd9, 5'd10);
      tick();
      tick();
      drv = add_i(5'd10, 5'd2, 5'd12, 32'd3, 32'd4);
      tick();
      tick();
      chk("lit_b2b_count", bus.stall_count, 4'd3);

      // Flush beats a simultaneous hazard.
      drv = lw_i(5'd29, 5'd9);
      tick();
      drv = add_i(5'd9, 5'd9, 5'd13, 32'd6, 32'd6);
      flush = 1'b1;
      #2 chk("lit_flush_nostall", bus.stall, 1'b0);
      tick();
      flush = 1'b0;
      chk("lit_flush_counts", {bus.flush_count, bus.stall_count}, {4'd1, 4'd3});
      chk("lit_flush_bubble", got.valid, 1'b0);
      tick();

      // Reset in the middle of a stall discards everything.
      drv = lw_i(5'd29, 5'd9);
      tick();
      drv = add_i(5'd9, 5'd1, 5'd14, 32'd8, 32'd8);
      Reset = 1'b0;
      #2 chk("lit_rst_stall", bus.stall, 1'b0);
      tick();
      chk("lit_rst_clear", {got.valid, bus.stall_count, bus.flush_count}, 9'd0);
      Reset = 1'b1;

      // Empty decode slot yields a bubble even with live-looking fields.
      drv = add_i(5'd1, 5'd2, 5'd3, 32'd9, 32'd9);
      drv.valid = 1'b0;
      tick();
      chk("lit_invalid_bubble", {got.valid, got.reg_write}, 2'b00);

      // Counter saturation.
      flush = 1'b1;
      drv = add_i(5'd1, 5'd2, 5'd3, 32'd9, 32'd9);
      for (int i = 0; i < (1 << CNT_W) + 3; i++) tick();
      flush = 1'b0;
      chk("lit_flush_sat", bus.flush_count, 4'd15);
      for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
         drv = lw_i(5'd29, 5'd9);
         tick();
         drv = add_i(5'd9, 5'd2, 5'd3, 32'd1, 32'd1);
         tick();
         tick();
      end
      chk("lit_stall_sat", bus.stall_count, 4'd15);

      // Random tail with frequent register overlap.
      Reset = 1'b0;
      tick();
      Reset = 1'b1;
      for (int i = 0; i < 200; i++) begin
         drv   = rand_rec();
         flush = ($urandom_range(0, 7) == 0);
         tick();
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly downstream of the instruction decoder (controller).
- Captures decoded control fields, register operands and the immediate each cycle, and presents them to the EX stage.
- Contains load-use hazard detection. It inserts a one-cycle bubble and stalls PC/IF-ID, or inserts a bubble on a flush from branch/jump resolution.
- Keeps saturating stall and flush counters for debug.

Parameters:
DATA_W, 32, operand/PC width
REG_AW, 5, register-address width
CNT_W, 16, width of stall/flush debug counters

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-low reset
id_valid  input  1  decode slot holds a real instruction
id_RegWrite, id_RegDst, id_ALUSrc, id_Branch, id_MemWrite, id_MemRead, id_MemToReg, id_Jump  input  1 each  decoder control outputs
id_ALUOp  input  4  decoder ALU op; 4'b1111 = NOP
id_MemSize  input  2  00 word, 01 half, 10 byte
id_PCPlus4, id_ReadData1, id_ReadData2, id_Imm  input  DATA_W each  PC+4, rs value, rt value, sign-extended immediate
id_Rs, id_Rt, id_Rd  input  REG_AW each  register specifiers
flush  input  1  branch/jump taken in EX; kill instruction entering EX
ex_valid  output  1  EX slot holds a real instruction
ex_RegWrite, ex_RegDst, ex_ALUSrc, ex_Branch, ex_MemWrite, ex_MemRead, ex_MemToReg, ex_Jump  output  1 each  registered control
ex_ALUOp  output  4  registered ALU op
ex_MemSize  output  2  registered access size
ex_PCPlus4, ex_ReadData1, ex_ReadData2, ex_Imm  output  DATA_W each  registered datapath values
ex_Rs, ex_Rt, ex_Rd  output  REG_AW each  registered specifiers
stall  output  1  combinational; hold PC and IF/ID this cycle
stall_count, flush_count  output  CNT_W each  saturating event counters

Behaviour:
- Reset (Reset==0 at a rising edge):
  - All ex_* outputs are 0, except ex_ALUOp = 4'b1111.
  - ex_valid=0; both counters are 0.
  - stall=0 while in reset.
- Bubble is defined as ex_valid=0, all ex_* 1-bit controls 0, ex_ALUOp=4'b1111, ex_MemSize=00. Datapath/specifier outputs are don't-care in a bubble but are forced to 0 for determinism.
- uses_rt = (id_ALUSrc==0) | id_MemWrite.
- hazard = ex_valid & ex_MemRead & (ex_Rt!=0) & id_valid & ((ex_Rt==id_Rs) | (uses_rt & ex_Rt==id_Rt)).
- stall = hazard & ~flush. Purely combinational from the registered ex_* outputs and id_* inputs.
- Next-state priority at each rising edge (Reset high):
  1. flush=1: load bubble; flush_count+=1 (saturating); stall forced 0.
  2. else hazard=1: load bubble; stall_count+=1 (saturating). The IF/ID holds, so the same instruction is re-presented next cycle. The hazard then clears because ex_MemRead=0, giving exactly one bubble per load-use.
  3. else id_valid=0: load bubble.
  4. else: capture all id_* fields; ex_valid=1.
- Latency is 1 cycle from id_* to ex_*; there is no other buffering.
- Control encoding is passed unmodified.
  - MemToReg=1 selects the ALU result; 0 selects memory.
  - RegDst=1 selects rd.
- Counters saturate at all-ones; they never wrap.
- Back-to-back loads each with a dependent consumer: each produces its own single bubble.
- Reset asserted mid-stall: reset wins and the bubble state is discarded.

Decomposition:
- Shared package holds:
  - ALUOp encodings: AND 0000, OR 0001, ADD 0010, SUB 0011, SLT 0100, NOR 0101, EQ 0110, SLL 1000, SRL 1001, XOR 1010, BLTZ 1011, BGEZ/BLEZ 1100, BGTZ 1101, MUL 1110, NOP 1111.
  - MemSize encodings.
  - A bubble control constant.
- One sub-module is natural: hazard_detect (pure combinational, computes hazard/stall). The register and counters live in id_ex_stage.

Test Plan:
- Reset: Reset=0 for 2 cycles with random id_* inputs -> ex_valid=0, ex_ALUOp=1111, counters 0, stall=0.
- Pass-through: add (RegWrite=1, RegDst=1, ALUOp=0010, rs=8, rt=9, rd=10, RD1=5, RD2=7) -> next cycle ex_* matches exactly, ex_valid=1, stall=0.
- Load-use:
  - lw $t1 (ex_MemRead=1, ex_Rt=9) in EX, then add with id_Rs=9 -> stall=1 for one cycle, bubble in EX, stall_count=1.
  - Next cycle the add is captured and stall=0.
- No false stall:
  - lw to rt=9, then addi with id_Rt=9, ALUSrc=1, id_Rs=4 -> stall=0.
  - lw with ex_Rt=0 followed by a user of $0 -> stall=0.
- Flush vs stall: hazard condition present and flush=1 in the same cycle -> stall=0, bubble loaded, flush_count=1, stall_count unchanged.
- Saturation: force 2^CNT_W+3 flush cycles (CNT_W overridden to 4) -> flush_count holds at 15.
